// File: rtl/fft_peak_detect.sv
// fft_peak_detect: per-frame power peak search over a streaming FFT output.
// Optional build macro FFT_PEAK_DC_SKIP_EN excludes bin 0 from the search.
module fft_peak_detect #(
    parameter int NPTS = 256,
    parameter int DW   = 20
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic signed [DW-1:0]      realin,
    input  logic signed [DW-1:0]      imagin,
    input  logic                      startin,
    output logic                      peak_valid,
    output logic [$clog2(NPTS)-1:0]   peak_bin,
    output logic [2*DW-1:0]           peak_pow,
    output logic                      frame_err
);
    localparam int LW = $clog2(NPTS);
    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t             state;
    logic [LW-1:0]      cnt;
    logic               acc;
    logic               abort;
    logic               keep;
    logic               first;
    logic               is_last;
    logic [LW-1:0]      bin;
    logic               s1_v, s1_first, s1_last;
    logic [LW-1:0]      s1_bin;
    logic signed [2*DW-2:0] s1_re, s1_im;
    logic               s2_v, s2_first, s2_last;
    logic [LW-1:0]      s2_bin;
    logic [2*DW-2:0]    s2_re2, s2_im2;
    logic               s3_v, s3_first, s3_last;
    logic [LW-1:0]      s3_bin;
    logic [2*DW-1:0]    s3_pow;
    logic [2*DW-1:0]    max_pow, cand_pow;
    logic [LW-1:0]      max_bin, cand_bin;
    logic               take;
    always_comb begin
        acc     = startin || state == ACTIVE;
        abort   = startin && state == ACTIVE;
        bin     = startin ? '0 : cnt;
        is_last = &bin;
`ifdef FFT_PEAK_DC_SKIP_EN
        keep    = bin != '0;
        first   = bin == LW'(1);
`else
        keep    = 1'b1;
        first   = bin == '0;
`endif
        // Strict compare keeps the earliest bin on ties
        take     = s3_first || s3_pow > max_pow;
        cand_pow = take ? s3_pow : max_pow;
        cand_bin = take ? s3_bin : max_bin;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            frame_err  <= 1'b0;
            s1_v       <= 1'b0;
            s1_first   <= 1'b0;
            s1_last    <= 1'b0;
            s1_bin     <= '0;
            s1_re      <= '0;
            s1_im      <= '0;
            s2_v       <= 1'b0;
            s2_first   <= 1'b0;
            s2_last    <= 1'b0;
            s2_bin     <= '0;
            s2_re2     <= '0;
            s2_im2     <= '0;
            s3_v       <= 1'b0;
            s3_first   <= 1'b0;
            s3_last    <= 1'b0;
            s3_bin     <= '0;
            s3_pow     <= '0;
            max_pow    <= '0;
            max_bin    <= '0;
            peak_valid <= 1'b0;
            peak_bin   <= '0;
            peak_pow   <= '0;
        end else begin
            frame_err <= abort;
            if (acc) begin
                state <= is_last ? IDLE : ACTIVE;
                cnt   <= bin + 1'b1;
            end
            s1_v     <= acc && keep;
            s1_first <= first;
            s1_last  <= is_last;
            s1_bin   <= bin;
            s1_re    <= {{(DW-1){realin[DW-1]}}, realin};
            s1_im    <= {{(DW-1){imagin[DW-1]}}, imagin};
            s2_v     <= s1_v;
            s2_first <= s1_first;
            s2_last  <= s1_last;
            s2_bin   <= s1_bin;
            s2_re2   <= s1_re * s1_re;
            s2_im2   <= s1_im * s1_im;
            s3_v     <= s2_v;
            s3_first <= s2_first;
            s3_last  <= s2_last;
            s3_bin   <= s2_bin;
            s3_pow   <= {1'b0, s2_re2} + {1'b0, s2_im2};
            if (s3_v) begin
                max_pow <= cand_pow;
                max_bin <= cand_bin;
            end
            peak_valid <= s3_v && s3_last;
            if (s3_v && s3_last) begin
                peak_bin <= cand_bin;
                peak_pow <= cand_pow;
            end
        end
    end
endmodule
